// File: rtl/mux4way_rr_pkg.sv
// rtl/mux4way_rr_pkg.sv - shared constants, FSM encoding and round-robin pick helper for mux4way_rr
// Optional packet-lock feature is enabled by defining MUX4WAY_PKT_LOCK_EN.
package mux4way_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Returns {found, idx}; offsets are visited high-to-low so the closest one to ptr wins.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                             input logic [SEL_W-1:0]  ptr);
    logic [SEL_W-1:0] idx;
    rr_pick = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

endpackage

// File: rtl/mux4way_rr_if.sv
// rtl/mux4way_rr_if.sv - four-source merge bus: source channels plus registered output stream
// in_last/out_last exist only when MUX4WAY_PKT_LOCK_EN is defined.
interface mux4way_rr_if #(parameter int WIDTH = 16);
  import mux4way_pkg::*;

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;
`ifdef MUX4WAY_PKT_LOCK_EN
  logic [NUM_CH-1:0]       in_last;
  logic                    out_last;

  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_data, out_sel, out_last);
  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_data, out_sel, out_last);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_sel);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_sel);
`endif

endinterface

// File: rtl/mux4way_rr_arbiter4.sv
// rtl/mux4way_rr_arbiter4.sv - combinational 4-way round-robin arbiter (req/ptr -> one-hot grant + index)
module rr_arbiter4
  import mux4way_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  idx,
  output logic [NUM_CH-1:0] grant
);

  always_comb begin
    {found, idx} = rr_pick(req, ptr);
    grant        = found ? (NUM_CH'(1) << idx) : '0;
  end

endmodule

// File: rtl/mux4way_rr.sv
// rtl/mux4way_rr.sv - 4-to-1 round-robin merge with registered, source-tagged output beat
// Define MUX4WAY_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module mux4way_rr
  import mux4way_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  mux4way_rr_if.slave  bus
);

  logic              load;
  logic              xfer;
  logic              ptr_upd;
  logic [SEL_W-1:0]  rr_ptr;
  logic [NUM_CH-1:0] req;
  logic [SEL_W-1:0]  ptr;
  logic              found;
  logic [SEL_W-1:0]  idx;
  logic [NUM_CH-1:0] grant;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [SEL_W-1:0]  out_sel_q;

  // in_ready path: in_valid/out_ready -> arbiter -> in_ready, no register in between.
  assign load = ~out_valid_q | bus.out_ready;
  assign xfer = found & load & ~reset;

  rr_arbiter4 u_arb (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .idx   (idx),
    .grant (grant)
  );

  assign bus.in_ready  = xfer ? grant : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

`ifdef MUX4WAY_PKT_LOCK_EN
  state_t           state, state_nx;
  logic [SEL_W-1:0] lk, lk_nx;
  logic             out_last_q;

  // While locked only the owning channel may request, even when it is idle.
  assign req          = (state == ST_LOCKED) ? (bus.in_valid & (NUM_CH'(1) << lk)) : bus.in_valid;
  assign ptr          = (state == ST_LOCKED) ? lk : rr_ptr;
  assign ptr_upd      = xfer & bus.in_last[idx];
  assign bus.out_last = out_last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_ARB;
      lk    <= '0;
    end else begin
      state <= state_nx;
      lk    <= lk_nx;
    end
  end

  always_comb begin
    state_nx = state;
    lk_nx    = lk;
    if (xfer) begin
      case (state)
        ST_ARB: begin
          if (!bus.in_last[idx]) begin
            state_nx = ST_LOCKED;
            lk_nx    = idx;
          end
        end
        ST_LOCKED: begin
          if (bus.in_last[idx]) state_nx = ST_ARB;
        end
        default: state_nx = ST_ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)     out_last_q <= 1'b0;
    else if (xfer) out_last_q <= bus.in_last[idx];
  end
`else
  assign req     = bus.in_valid;
  assign ptr     = rr_ptr;
  assign ptr_upd = xfer;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr      <= '0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.in_data[idx*WIDTH +: WIDTH];
        out_sel_q   <= idx;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      // 2-bit add wraps 3 -> 0 on its own.
      if (ptr_upd) rr_ptr <= idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_mux4way_rr.sv
// tb/tb_mux4way_rr.sv - scoreboard bench for mux4way_rr; exercises lock mode when MUX4WAY_PKT_LOCK_EN is defined
module tb_mux4way_rr;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  logic [15:0] ch_data [4];
  beat_t       sb [$];
  logic [1:0]  m_ptr;
  logic [1:0]  m_lk;
  logic        m_locked;
  logic        m_ov;

  mux4way_rr_if #(.WIDTH(16)) bus ();

  mux4way_rr #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic drive_data();
    bus.in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};
  endtask

  task automatic do_reset(input int n);
    reset         = 1'b1;
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b1;
    drive_data();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_in_ready", 32'(bus.in_ready), 0);
      check("rst_out_data", 32'(bus.out_data), 0);
      check("rst_out_sel", 32'(bus.out_sel), 0);
`ifdef MUX4WAY_PKT_LOCK_EN
      check("rst_out_last", 32'(bus.out_last), 0);
`endif
    end
    reset    = 1'b0;
    m_ptr    = 2'd0;
    m_lk     = 2'd0;
    m_locked = 1'b0;
    m_ov     = 1'b0;
    sb.delete();
  endtask

  // One clock: drive at negedge, check combinational ready and output reg, predict, advance.
  task automatic cycle(input logic [3:0] v, input logic rdy, input logic [3:0] last);
    logic       load;
    logic       found;
    logic [1:0] g;
    logic [3:0] exp_rdy;
    beat_t      b;
    bus.in_valid  = v;
    bus.out_ready = rdy;
    drive_data();
`ifdef MUX4WAY_PKT_LOCK_EN
    bus.in_last = last;
`endif
    #1;
    load  = !m_ov || rdy;
    found = 1'b0;
    g     = 2'd0;
    if (m_locked) begin
      found = v[m_lk];
      g     = m_lk;
    end else begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (int'(m_ptr) + k) % 4;
        if (!found && v[c]) begin
          found = 1'b1;
          g     = 2'(c);
        end
      end
    end
    exp_rdy = (found && load) ? (4'b0001 << g) : 4'b0000;
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (m_ov) begin
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        check("out_data", 32'(bus.out_data), 32'(sb[0].data));
        check("out_sel", 32'(bus.out_sel), 32'(sb[0].sel));
`ifdef MUX4WAY_PKT_LOCK_EN
        check("out_last", 32'(bus.out_last), 32'(sb[0].last));
`endif
        if (rdy) void'(sb.pop_front());
      end
    end
    if (found && load) begin
      b.sel  = g;
      b.data = ch_data[g];
      b.last = last[g];
      sb.push_back(b);
      m_ov = 1'b1;
`ifdef MUX4WAY_PKT_LOCK_EN
      if (!m_locked) begin
        if (last[g]) m_ptr = g + 2'd1;
        else begin
          m_locked = 1'b1;
          m_lk     = g;
        end
      end else if (last[g]) begin
        m_locked = 1'b0;
        m_ptr    = g + 2'd1;
      end
`else
      m_ptr = g + 2'd1;
`endif
    end else if (rdy) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b1;
    bus.in_valid  = 4'h0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef MUX4WAY_PKT_LOCK_EN
    bus.in_last   = 4'hF;
`endif
    for (int i = 0; i < 4; i++) ch_data[i] = 16'h00A0 + 16'(i);
    @(negedge clk);

    do_reset(2);

    for (int i = 0; i < 8; i++) cycle(4'b1111, 1'b1, 4'hF);
    cycle(4'b0000, 1'b1, 4'hF);

    ch_data[2] = 16'h1234;
    for (int i = 0; i < 4; i++) cycle(4'b0100, 1'b1, 4'hF);
    for (int i = 0; i < 3; i++) cycle(4'b0100, 1'b0, 4'hF);
    ch_data[2] = 16'h5678;
    cycle(4'b0100, 1'b1, 4'hF);
    cycle(4'b0000, 1'b1, 4'hF);

    for (int i = 0; i < 4; i++) ch_data[i] = 16'h0C00 + 16'(i);
    cycle(4'b1000, 1'b1, 4'hF);
    cycle(4'b1000, 1'b0, 4'hF);
    do_reset(1);
    for (int i = 0; i < 4; i++) cycle(4'b1111, 1'b1, 4'hF);
    cycle(4'b0000, 1'b1, 4'hF);

`ifdef MUX4WAY_PKT_LOCK_EN
    do_reset(1);
    for (int i = 0; i < 4; i++) ch_data[i] = 16'hD000 + 16'(i);
    cycle(4'b0001, 1'b1, 4'hF);
    cycle(4'b1011, 1'b1, 4'b1001);
    cycle(4'b1011, 1'b1, 4'b1001);
    cycle(4'b1011, 1'b1, 4'b1011);
    cycle(4'b1001, 1'b1, 4'b1001);
    cycle(4'b1001, 1'b1, 4'b1001);
    cycle(4'b0000, 1'b1, 4'hF);
`endif

    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < 4; c++) ch_data[c] = 16'($urandom);
      cycle(4'($urandom), ($urandom_range(0, 3) != 0), 4'($urandom));
    end
    for (int i = 0; i < 40; i++) cycle(4'b0000, 1'b1, 4'hF);
    check("sb_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
